// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet switch: packet field layout and node address map.
package noc_pkg;

   localparam int DEF_NUM_PORTS  = 5;
   localparam int DEF_DATA_WIDTH = 40;
   localparam int DEF_ADDR_WIDTH = 3;

   localparam logic [2:0] MEM   = 3'b110;
   localparam logic [2:0] PE0   = 3'b011;
   localparam logic [2:0] PE1   = 3'b001;
   localparam logic [2:0] PE2   = 3'b000;
   localparam logic [2:0] ADDER = 3'b100;

   // Output port o owns bits [o*3 +: 3]; port 0 is Mem.
   localparam logic [14:0] DEF_PORT_ADDR = {ADDER, PE2, PE1, PE0, MEM};

   // Layout is {ifm/filt, dest, src, data}.
   function automatic int pkt_width(input int dw, input int aw);
      return dw + 2 * aw + 1;
   endfunction

   function automatic int dest_lsb(input int dw, input int aw);
      return dw + aw;
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO used as the per-input packet buffer; head is the oldest entry.
module noc_sync_fifo #(
   parameter int WIDTH = 47,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // The extra MSB distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= data;
   end

endmodule

// File: rtl/noc_router_rr.sv
// Buffered NoC packet switch: per-input FIFOs, destination decode, per-output round-robin
// arbitration into a one-deep output register, and counting of unmapped-destination drops.
module noc_router_rr
   import noc_pkg::*;
#(
   parameter int NUM_PORTS  = DEF_NUM_PORTS,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_ADDR = DEF_PORT_ADDR,
   parameter int PKT_WIDTH  = pkt_width(DATA_WIDTH, ADDR_WIDTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PORTS-1:0]           in_valid,
   output logic [NUM_PORTS-1:0]           in_ready,
   input  logic [NUM_PORTS*PKT_WIDTH-1:0] in_data,
   output logic [NUM_PORTS-1:0]           out_valid,
   input  logic [NUM_PORTS-1:0]           out_ready,
   output logic [NUM_PORTS*PKT_WIDTH-1:0] out_data,
   output logic [NUM_PORTS-1:0]           drop_pulse,
   output logic [15:0]                    drop_count
);

   localparam int DEST_LSB = dest_lsb(DATA_WIDTH, ADDR_WIDTH);
   localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [PW:0] NP_W = (PW + 1)'(NUM_PORTS);

   // Handshake: a transfer happens on a rising edge where valid && ready; a valid
   // producer holds its data stable until then, and ready never depends on valid.

   logic [NUM_PORTS-1:0]                full;
   logic [NUM_PORTS-1:0]                empty;
   logic [NUM_PORTS-1:0]                push;
   logic [NUM_PORTS-1:0]                pop;
   logic [NUM_PORTS-1:0]                unmapped;
   logic [NUM_PORTS-1:0]                out_free;
   logic [PKT_WIDTH-1:0]                head [NUM_PORTS];
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] match;  // [input][output]
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt;    // [output][input]
   logic [16:0]                         n_drop;
   logic [16:0]                         drop_sum;

   assign in_ready = ~full;
   assign out_free = ~out_valid | out_ready;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
      logic [NUM_PORTS-1:0] m;

      assign push[i] = in_valid[i] && !full[i];

      noc_sync_fifo #(
         .WIDTH (PKT_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[i]),
         .pop   (pop[i]),
         .data  (in_data[i*PKT_WIDTH +: PKT_WIDTH]),
         .head  (head[i]),
         .full  (full[i]),
         .empty (empty[i])
      );

      always_comb begin
         m = '0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            m[o] = !empty[i] &&
                   (head[i][DEST_LSB +: ADDR_WIDTH] == PORT_ADDR[o*ADDR_WIDTH +: ADDR_WIDTH]);
         end
      end

      assign match[i]    = m;
      assign unmapped[i] = !empty[i] && (m == '0);
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
      logic [NUM_PORTS-1:0] req;
      logic [NUM_PORTS-1:0] g;
      logic [PW-1:0]        g_idx;
      logic [PW:0]          cand;
      logic [PKT_WIDTH-1:0] sel;
      logic [PW-1:0]        rr_ptr;
      logic                 valid_q;
      logic [PKT_WIDTH-1:0] data_q;

      // Search starts one past the last grant; only the first hit is taken.
      always_comb begin
         req   = '0;
         g     = '0;
         g_idx = '0;
         cand  = '0;
         sel   = '0;
         for (int i = 0; i < NUM_PORTS; i++) req[i] = match[i][o];
         for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = {1'b0, rr_ptr} + (PW + 1)'(k);
            if (cand >= NP_W) cand = cand - NP_W;
            if (out_free[o] && (g == '0) && req[cand[PW-1:0]]) begin
               g[cand[PW-1:0]] = 1'b1;
               g_idx           = cand[PW-1:0];
            end
         end
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (g[i]) sel = head[i];
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rr_ptr  <= PW'(NUM_PORTS - 1);
            valid_q <= 1'b0;
            data_q  <= '0;
         end else if (out_free[o]) begin
            valid_q <= (g != '0);
            if (g != '0) begin
               rr_ptr <= g_idx;
               data_q <= sel;
            end
         end
      end

      assign gnt[o]                                = g;
      assign out_valid[o]                          = valid_q;
      assign out_data[o*PKT_WIDTH +: PKT_WIDTH]    = data_q;
   end

   // Destinations are unique, so at most one output grants a given head.
   always_comb begin
      pop = unmapped;
      for (int o = 0; o < NUM_PORTS; o++) pop = pop | gnt[o];
   end

   always_comb begin
      n_drop = '0;
      for (int i = 0; i < NUM_PORTS; i++) n_drop = n_drop + 17'(unmapped[i]);
      drop_sum = {1'b0, drop_count} + n_drop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_pulse <= '0;
         drop_count <= '0;
      end else begin
         drop_pulse <= unmapped;
         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

endmodule

// File: tb/tb_noc_router_rr.sv
// Directed bench for noc_router_rr: one task per scenario, inputs driven and outputs sampled at negedge.
module tb_noc_router_rr;

   localparam int NP  = 5;
   localparam int PKW = 47;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     in_valid;
   logic [NP-1:0]     in_ready;
   logic [NP*PKW-1:0] in_data;
   logic [NP-1:0]     out_valid;
   logic [NP-1:0]     out_ready;
   logic [NP*PKW-1:0] out_data;
   logic [NP-1:0]     drop_pulse;
   logic [15:0]       drop_count;

   int checks = 0;
   int errors = 0;

   logic [PKW-1:0] exp_q [$];
   logic [2:0]     addr_of [NP] = '{3'b110, 3'b011, 3'b001, 3'b000, 3'b100};

   always #5 clk = ~clk;

   noc_router_rr dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .drop_pulse (drop_pulse),
      .drop_count (drop_count)
   );

   function automatic logic [PKW-1:0] mk(input logic f, input logic [2:0] d,
                                         input logic [2:0] s, input logic [39:0] dat);
      return {f, d, s, dat};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = '1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (in_ready !== 5'b11111) begin errors++; $display("FAIL reset_in_ready: got %b expected 11111", in_ready); end
      checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL reset_out_valid: got %b expected 00000", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      checks++; if (drop_pulse !== 5'b00000) begin errors++; $display("FAIL reset_drop_pulse: got %b expected 00000", drop_pulse); end
      checks++; if (drop_count !== 16'h0000) begin errors++; $display("FAIL reset_drop_count: got %h expected 0000", drop_count); end
   endtask

   task automatic test_single();
      logic [PKW-1:0]    pkt;
      logic [NP*PKW-1:0] ev;
      apply_reset();
      pkt = mk(1'b0, 3'b011, 3'b110, 40'd5);
      in_data[0 +: PKW] = pkt;
      in_valid = 5'b00001;
      tick();
      in_valid = '0;
      checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL single_early: got %b expected 00000", out_valid); end
      tick();
      ev = '0;
      ev[1*PKW +: PKW] = pkt;
      checks++; if (out_valid !== 5'b00010) begin errors++; $display("FAIL single_valid: got %b expected 00010", out_valid); end
      checks++; if (out_data !== ev) begin errors++; $display("FAIL single_data: got %h expected %h", out_data, ev); end
      tick();
      checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL single_consumed: got %b expected 00000", out_valid); end
   endtask

   task automatic test_round_robin();
      logic [PKW-1:0] e;
      apply_reset();
      for (int s = 0; s < 3; s++)
         for (int p = 1; p <= 3; p++)
            exp_q.push_back(mk(1'b0, 3'b110, addr_of[p], 40'(p * 16 + s)));
      for (int c = 0; c < 12; c++) begin
         if (c < 3) begin
            for (int p = 1; p <= 3; p++) in_data[p*PKW +: PKW] = mk(1'b0, 3'b110, addr_of[p], 40'(p * 16 + c));
            in_valid = 5'b01110;
         end else begin
            in_valid = '0;
         end
         if (c >= 2 && c <= 10) begin
            e = exp_q.pop_front();
            checks++; if (out_valid[0] !== 1'b1 || out_data[0 +: PKW] !== e) begin
               errors++; $display("FAIL rr_order[%0d]: got v=%b %h expected v=1 %h", c - 2, out_valid[0], out_data[0 +: PKW], e);
            end
         end
         if (c == 11) begin
            checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL rr_idle: got %b expected 00000", out_valid); end
         end
         tick();
      end
   endtask

   task automatic test_back_pressure();
      logic [PKW-1:0] e;
      apply_reset();
      out_ready = 5'b01111;
      for (int k = 0; k < 5; k++) begin
         checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 1", k, in_ready[0]); end
         in_data[0 +: PKW] = mk(1'b1, 3'b100, 3'b110, 40'(100 + k));
         exp_q.push_back(in_data[0 +: PKW]);
         in_valid = 5'b00001;
         tick();
      end
      in_data[0 +: PKW] = mk(1'b1, 3'b100, 3'b110, 40'd105);
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", in_ready[0]); end
      checks++; if (out_valid !== 5'b10000) begin errors++; $display("FAIL bp_held: got %b expected 10000", out_valid); end
      tick();
      in_valid = '0;
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_still_full: got %b expected 0", in_ready[0]); end
      out_ready = '1;
      for (int k = 0; k < 5; k++) begin
         e = exp_q.pop_front();
         checks++; if (out_valid[4] !== 1'b1 || out_data[4*PKW +: PKW] !== e) begin
            errors++; $display("FAIL bp_drain[%0d]: got v=%b %h expected v=1 %h", k, out_valid[4], out_data[4*PKW +: PKW], e);
         end
         tick();
      end
      checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL bp_after: got %b expected 00000", out_valid); end
   endtask

   task automatic test_drop();
      apply_reset();
      in_data[2*PKW +: PKW] = mk(1'b0, 3'b111, 3'b001, 40'hAB);
      in_valid = 5'b00100;
      tick();
      in_valid = '0;
      checks++; if (drop_pulse !== 5'b00000) begin errors++; $display("FAIL drop_early: got %b expected 00000", drop_pulse); end
      tick();
      checks++; if (drop_pulse !== 5'b00100) begin errors++; $display("FAIL drop_pulse: got %b expected 00100", drop_pulse); end
      checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_count1: got %0d expected 1", drop_count); end
      checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL drop_no_out: got %b expected 00000", out_valid); end
      tick();
      checks++; if (drop_pulse !== 5'b00000) begin errors++; $display("FAIL drop_one_cycle: got %b expected 00000", drop_pulse); end
      for (int p = 0; p < NP; p++) in_data[p*PKW +: PKW] = mk(1'b0, 3'b111, addr_of[p], 40'(p));
      in_valid = '1;
      tick();
      checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_multi_early: got %0d expected 1", drop_count); end
      tick();
      checks++; if (drop_count !== 16'd6) begin errors++; $display("FAIL drop_multi: got %0d expected 6", drop_count); end
      checks++; if (drop_pulse !== 5'b11111) begin errors++; $display("FAIL drop_multi_pulse: got %b expected 11111", drop_pulse); end
      repeat (13200) tick();
      checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL drop_sat: got %h expected FFFF", drop_count); end
      in_valid = '0;
      tick();
      tick();
      checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL drop_sat_hold: got %h expected FFFF", drop_count); end
      checks++; if (drop_pulse !== 5'b00000) begin errors++; $display("FAIL drop_quiet: got %b expected 00000", drop_pulse); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      out_ready = '0;
      for (int k = 0; k < 4; k++) begin
         in_data[1*PKW +: PKW] = mk(1'b0, 3'b110, 3'b011, 40'(200 + k));
         in_valid = 5'b00010;
         tick();
      end
      in_valid = '0;
      checks++; if (out_valid !== 5'b00001) begin errors++; $display("FAIL mid_loaded: got %b expected 00001", out_valid); end
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL mid_valid: got %b expected 00000", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_data: got %h expected 0", out_data); end
      checks++; if (in_ready !== 5'b11111) begin errors++; $display("FAIL mid_ready: got %b expected 11111", in_ready); end
      out_ready = '1;
      in_valid  = 5'b00010;
      tick();
      checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL mid_ignored: got %b expected 00000", out_valid); end
      rst      = 1'b0;
      in_valid = '0;
      tick();
      tick();
      checks++; if (out_valid !== 5'b00000) begin errors++; $display("FAIL mid_flushed: got %b expected 00000", out_valid); end
   endtask

   task automatic test_loopback();
      logic [PKW-1:0] pkt;
      apply_reset();
      pkt = mk(1'b1, 3'b000, 3'b000, 40'h12345);
      in_data[3*PKW +: PKW] = pkt;
      in_valid = 5'b01000;
      tick();
      in_valid = '0;
      tick();
      checks++; if (out_valid !== 5'b01000) begin errors++; $display("FAIL loop_valid: got %b expected 01000", out_valid); end
      checks++; if (out_data[3*PKW +: PKW] !== pkt) begin errors++; $display("FAIL loop_data: got %h expected %h", out_data[3*PKW +: PKW], pkt); end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_back_pressure();
      test_drop();
      test_reset_mid();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
